// File: rtl/text_console_pkg.sv
// Shared definitions for the character console: control codes, FSM encoding, geometry defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_console_pkg;

    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 4;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2,
        ST_FILL   = 2'd3
    } state_t;

    // Printable glyph range stored at the cursor.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_mem.sv
// Character store: one write port, one registered read port, one combinational copy-source read.
// Latency: registered read 1 cycle (read-before-write); copy read is combinational.
// Backpressure: none, accepts a write and a read every cycle.
// Ports: i_clk/i_rst; i_we/i_wr_addr/i_wr_dat write; i_rd_addr -> o_rd_dat (registered);
//        i_cp_addr -> o_cp_dat (combinational, used while scrolling).
module console_mem
    import text_console_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_dat,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_dat,
    input  logic [AW-1:0] i_cp_addr,
    output logic [7:0]    o_cp_dat
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Addresses past the end only exist when DEPTH is not a power of two; show blanks there.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_dat <= CHR_SPACE;
        end else if (int'(i_rd_addr) < DEPTH) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end else begin
            r_rd_dat <= CHR_SPACE;
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_cp_dat = r_mem[i_cp_addr];

endmodule

// File: rtl/text_console.sv
// Character terminal: decodes UART bytes into a ROWS x COLS screen with cursor, wrap, scroll, clear.
// Latency: byte effects visible the edge after acceptance; scroll holds off input N cycles, clear N cycles.
// Backpressure: rx_ready low during CLEAR/SCROLL/FILL; upstream holds rx_valid until accepted.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid/rx_ready byte input; char_addr -> char_out
//        (1-cycle registered read); cursor_idx = row*COLS+col; busy while clearing or scrolling.
// Optional: define CONSOLE_CURSOR_EN for a blinking inverse-video cursor (adds BLINK_CYCLES).
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
`ifdef CONSOLE_CURSOR_EN
    , parameter int BLINK_CYCLES = 13500000
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic [$clog2(COLS*ROWS)-1:0]  char_addr,
    output logic [7:0]                    char_out,
    output logic [$clog2(COLS*ROWS)-1:0]  cursor_idx,
    output logic                          busy
);

    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [AW-1:0] CNT_CLEAR  = AW'(N - 1);
    localparam logic [AW-1:0] CNT_SCROLL = AW'(N - COLS - 1);
    localparam logic [AW-1:0] CNT_FILL   = AW'(COLS - 1);
    localparam logic [AW-1:0] LAST_ROW0  = AW'(N - COLS);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(COLS);

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_rx_ready;
    logic          r_busy;

    logic          w_accept;
    logic [AW-1:0] w_cursor;
    logic          w_we;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_wr_dat;
    logic [AW-1:0] w_cp_addr;
    logic [7:0]    w_cp_dat;
    logic [7:0]    w_rd_dat;

    assign w_accept = rx_valid && r_rx_ready;
    // COLS is a power of two, so concatenation is row*COLS+col.
    assign w_cursor = AW'({r_row, r_col});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == CNT_CLEAR) begin
                        r_cnt      <= '0;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_state    <= ST_IDLE;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_printable(rx_data)) begin
                            if (r_col == COL_LAST) begin
                                r_col <= '0;
                                if (r_row == ROW_LAST) begin
                                    r_state    <= ST_SCROLL;
                                    r_cnt      <= '0;
                                    r_rx_ready <= 1'b0;
                                    r_busy     <= 1'b1;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end else if (rx_data == CHR_CR) begin
                            r_col <= '0;
                        end else if (rx_data == CHR_LF) begin
                            if (r_row == ROW_LAST) begin
                                r_state    <= ST_SCROLL;
                                r_cnt      <= '0;
                                r_rx_ready <= 1'b0;
                                r_busy     <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else if (rx_data == CHR_BS) begin
                            if (r_col != '0) begin
                                r_col <= r_col - 1'b1;
                            end
                        end else if (rx_data == CHR_FF) begin
                            r_state    <= ST_CLEAR;
                            r_cnt      <= '0;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (r_cnt == CNT_SCROLL) begin
                        r_cnt   <= '0;
                        r_state <= ST_FILL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    if (r_cnt == CNT_FILL) begin
                        r_cnt      <= '0;
                        r_state    <= ST_IDLE;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Single write port shared by byte stores, backspace blanking, clear, scroll copy and fill.
    assign w_cp_addr = r_cnt + ROW_STRIDE;

    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = r_cnt;
        w_wr_dat  = CHR_SPACE;
        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
            end
            ST_SCROLL: begin
                w_we     = 1'b1;
                w_wr_dat = w_cp_dat;
            end
            ST_FILL: begin
                w_we      = 1'b1;
                w_wr_addr = LAST_ROW0 + r_cnt;
            end
            ST_IDLE: begin
                if (w_accept && is_printable(rx_data)) begin
                    w_we      = 1'b1;
                    w_wr_addr = w_cursor;
                    w_wr_dat  = rx_data;
                end else if (w_accept && (rx_data == CHR_BS) && (r_col != '0)) begin
                    w_we      = 1'b1;
                    w_wr_addr = w_cursor - AW'(1);
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
        // Reset abandons any in-flight write so CLEAR restarts cleanly.
        if (rst) begin
            w_we = 1'b0;
        end
    end

    console_mem #(
        .DEPTH (N),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_dat  (w_wr_dat),
        .i_rd_addr (char_addr),
        .o_rd_dat  (w_rd_dat),
        .i_cp_addr (w_cp_addr),
        .o_cp_dat  (w_cp_dat)
    );

`ifdef CONSOLE_CURSOR_EN
    logic [31:0]   r_blink_cnt;
    logic          r_blink_phase;
    logic [AW-1:0] r_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_addr_q      <= '0;
        end else begin
            r_addr_q <= char_addr;
            if (r_blink_cnt == 32'(BLINK_CYCLES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Inverse glyph via bit 7 when the registered read address sits on the cursor.
    assign char_out = ((r_addr_q == w_cursor) && !r_busy && r_blink_phase)
                      ? (w_rd_dat ^ 8'h80) : w_rd_dat;
`else
    assign char_out = w_rd_dat;
`endif

    assign rx_ready   = r_rx_ready;
    assign busy       = r_busy;
    assign cursor_idx = w_cursor;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console at default geometry: vector table for byte decode, scoreboard for reads,
// hand sequences for scroll latency, wrap-scroll with held input, backspace, reset during clear.
// Latency: n/a. Backpressure: stimulus holds rx_valid until rx_ready.
module tb_text_console;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [5:0] char_addr;
    logic [7:0] char_out;
    logic [5:0] cursor_idx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m [N];
    int mr, mc;
    logic [7:0] sb_q [$];

    typedef struct {
        logic [7:0] b;
        int         exp_cur;
    } vec_t;
    vec_t vt [10];

    always #5 clk = ~clk;

    text_console dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .char_addr  (char_addr),
        .char_out   (char_out),
        .cursor_idx (cursor_idx),
        .busy       (busy)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic model_scroll();
        for (int i = 0; i < N - 16; i++) m[i] = m[i + 16];
        for (int i = N - 16; i < N; i++) m[i] = 8'h20;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i] = 8'h20;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m[mr * 16 + mc] = b;
            if (mc == 15) begin
                mc = 0;
                if (mr == 3) model_scroll();
                else mr++;
            end else begin
                mc++;
            end
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h0A) begin
            if (mr == 3) model_scroll();
            else mr++;
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                m[mr * 16 + mc] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endtask

    // Holds the byte until accepted; returns one cycle after the acceptance edge.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rx_ready) begin
            check("send_timeout", int'(b), 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            model_byte(b);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < 500) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (busy) check({name, "_timeout"}, 0, 32'd1, 32'd0);
    endtask

    task automatic read_range(input int lo, input int hi);
        logic [7:0] e;
        for (int a = lo; a <= hi; a++) begin
            char_addr = 6'(a);
            sb_q.push_back(m[a]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            check("rd", a, 32'(char_out), 32'(e));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vt[0] = '{8'h48, 1};   // 'H'
        vt[1] = '{8'h49, 2};   // 'I'
        vt[2] = '{8'h07, 2};   // ignored control
        vt[3] = '{8'h08, 1};   // BS
        vt[4] = '{8'h49, 2};   // 'I'
        vt[5] = '{8'h0D, 0};   // CR
        vt[6] = '{8'h0A, 16};  // LF
        vt[7] = '{8'h42, 17};  // 'B'
        vt[8] = '{8'h08, 16};  // BS
        vt[9] = '{8'h08, 16};  // BS at col 0 is a no-op

        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        char_addr = 6'd0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_out", 0, 32'(char_out), 32'h20);
        check("rst_rx_ready", 0, 32'(rx_ready), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd1);
        check("rst_cursor", 0, 32'(cursor_idx), 32'd0);
        rst = 1'b0;
        wait_idle("clear", cyc);
        check("clear_cycles", 0, 32'(cyc), 32'd64);
        check("clear_rx_ready", 0, 32'(rx_ready), 32'd1);
        read_range(0, N - 1);

        // Byte decode table
        for (int i = 0; i < 10; i++) begin
            send_byte(vt[i].b);
            check("vec_cursor", i, 32'(cursor_idx), 32'(vt[i].exp_cur));
        end
        read_range(0, 31);

        // Form feed, then wrap through row 0 into row 1 and down to row 2
        send_byte(8'h0C);
        wait_idle("ff", cyc);
        check("ff_cursor", 0, 32'(cursor_idx), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'h41);
        check("wrap_cursor", 0, 32'(cursor_idx), 32'd16);
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h42);
        check("crlf_cursor", 0, 32'(cursor_idx), 32'd33);
        send_byte(8'h0A);
        send_byte(8'h77);
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h7A);
        check("pre_scroll_cursor", 0, 32'(cursor_idx), 32'd53);
        read_range(0, N - 1);

        // LF on the last row scrolls: input held off for 64 cycles
        send_byte(8'h0A);
        cyc = 0;
        while (!rx_ready && cyc < 500) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("scroll_ready_low", 0, 32'(cyc), 32'd64);
        check("scroll_busy_done", 0, 32'(busy), 32'd0);
        check("scroll_cursor", 0, 32'(cursor_idx), 32'd53);
        read_range(0, N - 1);

        // Printable at the last cell wraps and scrolls; next byte is held until ready
        for (int i = 0; i < 10; i++) send_byte(8'h7A);
        check("last_cell_cursor", 0, 32'(cursor_idx), 32'd63);
        send_byte(8'h7A);
        check("wrap_scroll_busy", 0, 32'(busy), 32'd1);
        check("wrap_scroll_cursor", 0, 32'(cursor_idx), 32'd48);
        send_byte(8'h51);
        check("held_byte_cursor", 0, 32'(cursor_idx), 32'd49);
        read_range(0, N - 1);

        // Backspace down to column 0 and one more
        send_byte(8'h52);
        send_byte(8'h53);
        check("bs_start_cursor", 0, 32'(cursor_idx), 32'd51);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h08);
            check("bs_cursor", i, 32'(cursor_idx), 32'((i < 3) ? (50 - i) : 48));
        end
        read_range(32, N - 1);

        // Reset ten cycles into a clear restarts it from index 0
        send_byte(8'h0C);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", 0, 32'(busy), 32'd1);
        check("rst_mid_ready", 0, 32'(rx_ready), 32'd0);
        rst = 1'b0;
        wait_idle("reclear", cyc);
        check("reclear_cycles", 0, 32'(cyc), 32'd64);
        check("reclear_cursor", 0, 32'(cursor_idx), 32'd0);
        read_range(0, N - 1);

        // Same-cycle read and write of one address returns the old data
        char_addr = 6'd0;
        sb_q.push_back(m[0]);
        send_byte(8'h58);
        check("rbw_old", 0, 32'(char_out), 32'(sb_q.pop_front()));
        sb_q.push_back(m[0]);
        @(posedge clk); #1;
        check("rbw_new", 0, 32'(char_out), 32'(sb_q.pop_front()));
        check("rbw_new_const", 0, 32'(char_out), 32'h58);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
